// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single UART sender, with a
// watchdog on the sender handshake and a wrapping count of completed transfers.
module uart_tx_arbiter #(
  parameter logic [19:0] TIMEOUT = 20'd1000000
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  output logic        req0_done,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [7:0]  tx_data,
  output logic        tx_trigger,
  output logic        tx_enable,
  input  logic        tx_state,
  input  logic        tx_finish,
  output logic        timeout_err,
  output logic [15:0] sent_count
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 20;
  localparam int unsigned SENT_W = 16;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 20'd1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FIRE      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [DATA_W-1:0]   r_tx_data;
  logic                r_grant;
  logic                r_last_grant;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [SENT_W-1:0]   r_sent_count;
  logic                r_timeout_err;
  logic                w_sel;
  logic                w_hs;
  logic                w_expired;
  logic                w_abort;

  // Grant the sole valid requester, or the one not served last on contention.
  always_comb begin
    w_sel = 1'b0;
    if (req0_valid && req1_valid) w_sel = ~r_last_grant;
    else                          w_sel = req1_valid;
  end

  assign w_hs      = (r_state == IDLE) && reset && (req0_valid || req1_valid);
  assign w_expired = (r_wait_cnt >= LAST_CNT);

  always_ff @(posedge sysclk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Exit condition is checked before expiry so a late finish still completes.
  always_comb begin
    w_next_state = r_state;
    w_abort      = 1'b0;
    case (r_state)
      IDLE:      if (w_hs) w_next_state = FIRE;
      FIRE:      w_next_state = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_state)       w_next_state = WAIT_DONE;
        else if (w_expired) begin w_next_state = IDLE; w_abort = 1'b1; end
      end
      WAIT_DONE: begin
        if (tx_finish)      w_next_state = DONE;
        else if (w_expired) begin w_next_state = IDLE; w_abort = 1'b1; end
      end
      DONE:      w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    req0_done  = 1'b0;
    req1_done  = 1'b0;
    tx_trigger = 1'b0;
    tx_enable  = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = w_hs && !w_sel;
        req1_ready = w_hs &&  w_sel;
      end
      FIRE: begin
        tx_trigger = 1'b1;
        tx_enable  = 1'b1;
      end
      WAIT_BUSY, WAIT_DONE: tx_enable = 1'b1;
      DONE: begin
        req0_done = !r_grant;
        req1_done =  r_grant;
      end
      default: ;
    endcase
  end

  // Datapath: latched byte, grant history, watchdog and transfer counter.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_tx_data     <= '0;
      r_grant       <= 1'b0;
      r_last_grant  <= 1'b1;
      r_wait_cnt    <= '0;
      r_sent_count  <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_hs) begin
        r_tx_data <= w_sel ? req1_data : req0_data;
        r_grant   <= w_sel;
      end
      if (r_state == WAIT_BUSY || r_state == WAIT_DONE)
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      else
        r_wait_cnt <= '0;
      if (r_state == DONE) begin
        r_last_grant <= r_grant;
        r_sent_count <= r_sent_count + SENT_W'(1);
      end else if (w_abort) begin
        r_last_grant <= r_grant;
      end
      r_timeout_err <= w_abort;
    end
  end

  assign tx_data     = r_tx_data;
  assign sent_count  = r_sent_count;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: arbitration, sender handshake, watchdog,
// reset abort and transfer-counter wrap, all sampled on the falling edge.
module tb_uart_tx_arbiter;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready, req0_done, req1_done;
  logic [7:0]  tx_data;
  logic        tx_trigger, tx_enable, tx_state, tx_finish, timeout_err;
  logic [15:0] sent_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sysclk = ~sysclk;

  uart_tx_arbiter #(.TIMEOUT(20'd16)) dut (
    .sysclk(sysclk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready), .req1_done(req1_done),
    .tx_data(tx_data), .tx_trigger(tx_trigger), .tx_enable(tx_enable),
    .tx_state(tx_state), .tx_finish(tx_finish),
    .timeout_err(timeout_err), .sent_count(sent_count)
  );

  // Sender model: called in FIRE, returns with the DUT in DONE.
  task automatic drive_sender();
    @(negedge sysclk); tx_state = 1'b1;
    @(negedge sysclk); tx_state = 1'b0; tx_finish = 1'b1;
    @(negedge sysclk); tx_finish = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req0_valid = 1'b1; req1_valid = 1'b0;
    req0_data = 8'h5A; req1_data = 8'h00; tx_state = 1'b0; tx_finish = 1'b0;
    repeat (2) @(negedge sysclk);
    #1;
    n_tests++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready0 got=%b exp=0", req0_ready); end
    n_tests++; if (tx_enable !== 1'b0 || tx_trigger !== 1'b0) begin n_fail++; $display("FAIL rst_tx got en=%b trig=%b exp 0 0", tx_enable, tx_trigger); end
    n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_data got=%h exp=00", tx_data); end
    n_tests++; if (sent_count !== 16'h0000) begin n_fail++; $display("FAIL rst_count got=%h exp=0000", sent_count); end
    n_tests++; if ({req0_done, req1_done, timeout_err, req1_ready} !== 4'b0) begin n_fail++; $display("FAIL rst_pulses got=%b exp=0000", {req0_done, req1_done, timeout_err, req1_ready}); end
    req0_valid = 1'b0;
    @(negedge sysclk); reset = 1'b1;
  endtask

  task automatic test_single();
    @(negedge sysclk);
    req0_valid = 1'b1; req0_data = 8'hA5; #1;
    n_tests++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready got=%b%b exp=10", req0_ready, req1_ready); end
    @(negedge sysclk);
    req0_valid = 1'b0; req0_data = 8'hFF;
    n_tests++; if (tx_trigger !== 1'b1 || tx_enable !== 1'b1) begin n_fail++; $display("FAIL single_fire got trig=%b en=%b exp 1 1", tx_trigger, tx_enable); end
    n_tests++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got=%h exp=a5", tx_data); end
    @(negedge sysclk);
    n_tests++; if (tx_trigger !== 1'b0 || tx_enable !== 1'b1) begin n_fail++; $display("FAIL single_waitbusy got trig=%b en=%b exp 0 1", tx_trigger, tx_enable); end
    tx_state = 1'b1;
    @(negedge sysclk); tx_state = 1'b0; tx_finish = 1'b1;
    @(negedge sysclk); tx_finish = 1'b0;
    n_tests++; if (req0_done !== 1'b1 || req1_done !== 1'b0) begin n_fail++; $display("FAIL single_done got=%b%b exp=10", req0_done, req1_done); end
    n_tests++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_hold got=%h exp=a5", tx_data); end
    @(negedge sysclk);
    n_tests++; if (sent_count !== 16'd1 || req0_done !== 1'b0) begin n_fail++; $display("FAIL single_count got cnt=%0d done=%b exp 1 0", sent_count, req0_done); end
  endtask

  task automatic test_contention();
    logic exp_g;
    reset = 1'b0;
    @(negedge sysclk); reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h11; req1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      exp_g = 1'(i % 2);
      #1;
      n_tests++; if ({req0_ready, req1_ready} !== {~exp_g, exp_g}) begin n_fail++; $display("FAIL cont_grant%0d got=%b%b exp=%b%b", i, req0_ready, req1_ready, ~exp_g, exp_g); end
      @(negedge sysclk);
      n_tests++; if (tx_data !== (exp_g ? 8'h22 : 8'h11) || {req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL cont_data%0d got=%h rdy=%b%b", i, tx_data, req0_ready, req1_ready); end
      drive_sender();
      n_tests++; if ({req0_done, req1_done} !== {~exp_g, exp_g}) begin n_fail++; $display("FAIL cont_done%0d got=%b%b exp=%b%b", i, req0_done, req1_done, ~exp_g, exp_g); end
      @(negedge sysclk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_tests++; if (sent_count !== 16'd4) begin n_fail++; $display("FAIL cont_count got=%0d exp=4", sent_count); end
  endtask

  task automatic test_timeout();
    req0_valid = 1'b1; req0_data = 8'h3C;
    @(negedge sysclk); req0_valid = 1'b0;
    repeat (16) @(negedge sysclk);
    n_tests++; if (tx_enable !== 1'b1 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_early got en=%b err=%b exp 1 0", tx_enable, timeout_err); end
    @(negedge sysclk);
    n_tests++; if (timeout_err !== 1'b1 || tx_enable !== 1'b0) begin n_fail++; $display("FAIL to_pulse got err=%b en=%b exp 1 0", timeout_err, tx_enable); end
    n_tests++; if (sent_count !== 16'd4 || req0_done !== 1'b0) begin n_fail++; $display("FAIL to_count got cnt=%0d done=%b exp 4 0", sent_count, req0_done); end
    @(negedge sysclk);
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_once got=%b exp=0", timeout_err); end
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    n_tests++; if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL to_lastgrant got=%b%b exp=01", req0_ready, req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge sysclk);
  endtask

  task automatic test_finish_at_timeout();
    req0_valid = 1'b1; req0_data = 8'h77;
    @(negedge sysclk); req0_valid = 1'b0;
    @(negedge sysclk); tx_state = 1'b1;
    @(negedge sysclk); tx_state = 1'b0;
    repeat (14) @(negedge sysclk);
    n_tests++; if (tx_enable !== 1'b1) begin n_fail++; $display("FAIL race_wait got en=%b exp=1", tx_enable); end
    tx_finish = 1'b1;
    @(negedge sysclk); tx_finish = 1'b0;
    n_tests++; if (req0_done !== 1'b1 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL race_done got done=%b err=%b exp 1 0", req0_done, timeout_err); end
    @(negedge sysclk);
    n_tests++; if (timeout_err !== 1'b0 || sent_count !== 16'd5) begin n_fail++; $display("FAIL race_after got err=%b cnt=%0d exp 0 5", timeout_err, sent_count); end
  endtask

  task automatic test_reset_mid();
    req1_valid = 1'b1; req1_data = 8'hC3;
    @(negedge sysclk); req1_valid = 1'b0;
    @(negedge sysclk); tx_state = 1'b1;
    @(negedge sysclk); tx_state = 1'b0;
    n_tests++; if (tx_enable !== 1'b1 || tx_data !== 8'hC3) begin n_fail++; $display("FAIL mid_pre got en=%b data=%h exp 1 c3", tx_enable, tx_data); end
    reset = 1'b0;
    @(negedge sysclk); reset = 1'b1;
    n_tests++; if (tx_enable !== 1'b0 || tx_data !== 8'h00 || sent_count !== 16'h0) begin n_fail++; $display("FAIL mid_rst got en=%b data=%h cnt=%0d", tx_enable, tx_data, sent_count); end
    n_tests++; if ({req0_done, req1_done, timeout_err, tx_trigger} !== 4'b0) begin n_fail++; $display("FAIL mid_pulses got=%b exp=0000", {req0_done, req1_done, timeout_err, tx_trigger}); end
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    n_tests++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL mid_prio got=%b%b exp=10", req0_ready, req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge sysclk);
  endtask

  task automatic test_wrap();
    dut.r_sent_count = 16'hFFFE;
    for (int i = 0; i < 2; i++) begin
      @(negedge sysclk); req1_valid = 1'b1; req1_data = 8'h42;
      @(negedge sysclk); req1_valid = 1'b0;
      drive_sender();
      @(negedge sysclk);
      n_tests++; if (sent_count !== (i == 0 ? 16'hFFFF : 16'h0000)) begin n_fail++; $display("FAIL wrap%0d got=%h exp=%h", i, sent_count, (i == 0 ? 16'hFFFF : 16'h0000)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_finish_at_timeout();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 20'd1000000, meaning the maximum sysclk cycles spent waiting on the UART sender before aborting.
REQ-002 The block SHALL have port sysclk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1 bit each: requester 0/1 has a byte to send.
REQ-005 The block SHALL have ports req0_data / req1_data, input, 8 bits each: the byte offered by requester 0/1.
REQ-006 The block SHALL have ports req0_ready / req1_ready, output, 1 bit each: the byte is accepted in the cycle where valid and ready are both high.
REQ-007 The block SHALL have ports req0_done / req1_done, output, 1 bit each: one-cycle pulse when that requester's byte has finished transmission.
REQ-008 The block SHALL have port tx_data, output, 8 bits: the byte presented to the UART sender.
REQ-009 The block SHALL have port tx_trigger, output, 1 bit: start pulse to the UART sender.
REQ-010 The block SHALL have port tx_enable, output, 1 bit: baud-generator enable to the UART sender.
REQ-011 The block SHALL have port tx_state, input, 1 bit: sender busy indication.
REQ-012 The block SHALL have port tx_finish, input, 1 bit: sender frame-complete indication.
REQ-013 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse when a transfer is aborted.
REQ-014 The block SHALL have port sent_count, output, 16 bits: number of completed transfers, wrapping.

Function
REQ-015 The FSM SHALL have states IDLE, FIRE, WAIT_BUSY, WAIT_DONE and DONE.
REQ-016 In IDLE, req_ready SHALL be asserted combinationally to exactly one valid requester; no ready is asserted in any other state.
REQ-017 When only one requester is valid, it SHALL be granted; when both are valid, the one not recorded in last_grant SHALL be granted.
REQ-018 On handshake, the data SHALL be latched into tx_data, the grant index SHALL be latched, and the FSM SHALL move to FIRE.
REQ-019 FIRE SHALL last one cycle: tx_trigger=1 and tx_enable=1, then go to WAIT_BUSY.
REQ-020 tx_enable SHALL stay 1 in FIRE, WAIT_BUSY and WAIT_DONE, and be 0 otherwise.
REQ-021 tx_trigger SHALL be 1 only in FIRE.
REQ-022 WAIT_BUSY SHALL advance to WAIT_DONE on tx_state=1.
REQ-023 WAIT_DONE SHALL advance to DONE on tx_finish=1.
REQ-024 DONE SHALL last one cycle: pulse req_done for the granted requester, update last_grant, increment sent_count (modulo 2^16, 16'hFFFF -> 16'h0000), then return to IDLE.
REQ-025 A 20-bit wait counter SHALL clear on entry to WAIT_BUSY and count in WAIT_BUSY and WAIT_DONE.
REQ-026 When the wait counter reaches TIMEOUT-1 without the exit condition, the FSM SHALL go to IDLE and pulse timeout_err for one cycle; no done pulse, sent_count unchanged, last_grant updated.
REQ-027 If the exit condition and the timeout occur in the same cycle, the exit condition SHALL win.
REQ-028 tx_data SHALL hold its value until the next handshake; requester data changes after a handshake SHALL have no effect.
REQ-029 A requester deasserting valid without a handshake SHALL be legal; no state is kept for it.

Reset
REQ-030 While reset=0 at a rising edge, the block SHALL go to IDLE with tx_data=8'h00, tx_trigger=0, tx_enable=0, req_ready=0, req_done=0, timeout_err=0, sent_count=16'h0000, last_grant=1 (requester 0 has first priority), and wait counter=0.
REQ-031 Reset mid-transfer SHALL abort the transfer with no done or error pulse, and tx_enable SHALL drop in the cycle after the reset edge.

Verification
REQ-032 Single request: req0_valid=1, data 8'hA5 -> req0_ready high in the same cycle; next cycle tx_trigger=1 with tx_data=8'hA5; after the tx_state and tx_finish model responds, req0_done pulses and sent_count=1.
REQ-033 Contention: both requesters valid continuously with 8'h11 and 8'h22 -> grants alternate 0,1,0,1 after reset; the tx_data sequence is 11,22,11,22.
REQ-034 Timeout: TIMEOUT=16, tx_state is never asserted -> timeout_err pulses 16 cycles after WAIT_BUSY entry; tx_enable=0 afterwards; sent_count is unchanged.
REQ-035 Finish and timeout in the same cycle: tx_finish=1 on the last count -> DONE is taken, with no timeout_err.
REQ-036 Reset asserted during WAIT_DONE -> all outputs return to their reset values next cycle; a new request is then served by requester 0 first.
REQ-037 Wrap: preload via 65536 transfers (or force) -> sent_count goes 16'hFFFF to 16'h0000.
